// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: row drive and column sense toward the matrix,
// accepted key code / valid pulse / held flag toward the value register.
interface keypad_scanner_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  col_n,
        output row_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output col_n,
        input  row_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debounce.
// Drives one row low at a time, samples the active-low columns at the end of
// each row dwell, evaluates a 16-bit snapshot once per full scan, and reports
// a debounced single key as {row, col} with a one-cycle valid pulse.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV           = 2080,
    parameter int unsigned DEBOUNCE_SCANS     = 5,
    parameter int unsigned REPEAT_DELAY_SCANS = 125,
    parameter int unsigned REPEAT_RATE_SCANS  = 25
) (
    input logic               clk_i,
    input logic               reset,
    keypad_scanner_if.master  kp
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 2);

    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 ||
        REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    logic [DW-1:0] dwell;
    logic [1:0]    row;
    logic [3:0]    row_n;
    logic [15:0]   snap;
    logic [15:0]   snap_next;
    logic          sample;
    logic          eval;
    logic          cand_valid;
    logic [3:0]    cand_code;

    state_t        state;
    logic [3:0]    pend;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_held;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                                      REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int unsigned RW = $clog2(REP_MAX + 1);
    // Scans remaining until the next repeat pulse.
    logic [RW-1:0] rep_cnt;
`endif

    assign sample    = (dwell == DW'(SCAN_DIV - 1));
    assign eval      = sample && (row == 2'd3);
    assign count_inc = count + CW'(1);

    assign kp.row_n     = row_n;
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = key_held;

    // Snapshot including the row being sampled this cycle, plus single-key decode.
    always_comb begin
        snap_next = snap;
        if (sample) begin
            snap_next[{row, 2'b00} +: 4] = ~kp.col_n;
        end
        cand_valid = (snap_next != '0) && ((snap_next & (snap_next - 16'd1)) == '0);
        cand_code  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_next[i]) begin
                cand_code = 4'(i);
            end
        end
    end

    // Row dwell timing, row rotation and column snapshot capture.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            dwell <= '0;
            row   <= '0;
            row_n <= 4'b1110;
            snap  <= '0;
        end else begin
            snap <= snap_next;
            if (sample) begin
                dwell <= '0;
                row   <= row + 2'd1;
                row_n <= {row_n[2:0], row_n[3]};
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // Debounce FSM, stepped once per full scan; outputs registered here.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            count     <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (eval) begin
                case (state)
                    IDLE: begin
                        if (cand_valid) begin
                            pend <= cand_code;
                            if (DEBOUNCE_SCANS == 1) begin
                                key_code  <= cand_code;
                                key_held  <= 1'b1;
                                key_valid <= 1'b1;
                                count     <= '0;
                                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= RW'(REPEAT_DELAY_SCANS);
`endif
                            end else begin
                                count <= CW'(1);
                                state <= PRESS_DB;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (!cand_valid) begin
                            count <= '0;
                            state <= IDLE;
                        end else if (cand_code != pend) begin
                            pend  <= cand_code;
                            count <= CW'(1);
                        end else if (count_inc >= CW'(DEBOUNCE_SCANS)) begin
                            key_code  <= pend;
                            key_held  <= 1'b1;
                            key_valid <= 1'b1;
                            count     <= '0;
                            state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt   <= RW'(REPEAT_DELAY_SCANS);
`endif
                        end else begin
                            count <= count_inc;
                        end
                    end
                    HELD: begin
                        if (!(cand_valid && cand_code == key_code)) begin
                            count <= CW'(1);
                            state <= REL_DB;
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (rep_cnt == RW'(1)) begin
                            key_valid <= 1'b1;
                            rep_cnt   <= RW'(REPEAT_RATE_SCANS);
                        end else begin
                            rep_cnt <= rep_cnt - RW'(1);
                        end
`endif
                    end
                    REL_DB: begin
                        if (cand_valid && cand_code == key_code) begin
                            count <= '0;
                            state <= HELD;
                        end else if (count_inc >= CW'(DEBOUNCE_SCANS)) begin
                            key_held <= 1'b0;
                            count    <= '0;
                            state    <= IDLE;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt  <= '0;
`endif
                        end else begin
                            count <= count_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a scan-level reference model of the
// keypad decisions (run lengths of identical candidates), an every-cycle
// compare process, directed scenarios with literal expectations, then
// randomized key activity including mid-scan changes and resets.
module tb_keypad_scanner;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 2;
    localparam int unsigned RD = 4;
    localparam int unsigned RR = 2;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_HOLD_PULSES = 4;
`else
    localparam int EXP_HOLD_PULSES = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mask = '0;     // physically pressed keys, bit {row,col}
    logic [3:0]  col;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SCANS(DB),
        .REPEAT_DELAY_SCANS(RD),
        .REPEAT_RATE_SCANS(RR)
    ) dut (
        .clk_i(clk),
        .reset(reset),
        .kp(kp)
    );

    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (kp.row_n[r] == 1'b0) begin
                col = col & ~mask[4*r +: 4];
            end
        end
    end
    assign kp.col_n = col;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int first_idx = -1;
    int since_rst = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_live = 0;
    int unsigned m_t;            // cycle position within a scan
    logic [15:0] m_snap;
    logic [3:0]  m_row_n;
    logic [3:0]  m_code;
    logic        m_valid;
    logic        m_held;
    logic [3:0]  m_pend;
    int          run;            // consecutive scans with the same single key (not held)
    int          miss;           // consecutive scans not showing the held key
`ifdef KEYPAD_REPEAT_EN
    int          hscans;         // scans spent confirmed-held since acceptance
`endif

    task automatic model_eval();
        int   n;
        logic [3:0] cc;
        bit   cv;
        n  = $countones(m_snap);
        cv = (n == 1);
        cc = '0;
        for (int i = 0; i < 16; i++) if (m_snap[i]) cc = 4'(i);
        if (!m_held) begin
            if (cv) begin
                if (run > 0 && cc == m_pend) run++;
                else begin
                    m_pend = cc;
                    run = 1;
                end
                if (run >= int'(DB)) begin
                    m_code  = cc;
                    m_held  = 1'b1;
                    m_valid = 1'b1;
                    run = 0;
                    miss = 0;
`ifdef KEYPAD_REPEAT_EN
                    hscans = 0;
`endif
                end
            end else begin
                run = 0;
            end
        end else begin
            if (cv && cc == m_code) begin
                if (miss > 0) miss = 0;
`ifdef KEYPAD_REPEAT_EN
                else begin
                    hscans++;
                    if (hscans == int'(RD) ||
                        (hscans > int'(RD) && (hscans - int'(RD)) % int'(RR) == 0))
                        m_valid = 1'b1;
                end
`endif
            end else begin
                miss++;
                if (miss >= int'(DB)) begin
                    m_held = 1'b0;
                    miss = 0;
                    run = 0;
`ifdef KEYPAD_REPEAT_EN
                    hscans = 0;
`endif
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_live  = 1;
                m_t     = 0;
                m_snap  = '0;
                m_code  = '0;
                m_valid = 1'b0;
                m_held  = 1'b0;
                m_pend  = '0;
                run     = 0;
                miss    = 0;
`ifdef KEYPAD_REPEAT_EN
                hscans  = 0;
`endif
                since_rst = 0;
            end else begin
                int unsigned row;
                since_rst++;
                m_valid = 1'b0;
                row = (m_t / SD) % 4;
                if (m_t % SD == SD - 1) begin
                    m_snap[4*row +: 4] = mask[4*row +: 4];
                    if (row == 3) model_eval();
                end
                m_t = (m_t + 1) % (4 * SD);
            end
            m_row_n = ~(4'b0001 << ((m_t / SD) % 4));
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                chk("row_n", kp.row_n, m_row_n);
                chk("key_code", kp.key_code, m_code);
                chk("key_valid", kp.key_valid, m_valid);
                chk("key_held", kp.key_held, m_held);
                if (kp.key_valid === 1'b1) begin
                    pulse_cnt++;
                    if (first_idx < 0) first_idx = since_rst;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        pulse_cnt = 0;
        first_idx = -1;
    endtask

    task automatic wait_scans(input int n);
        repeat (n * 16) @(negedge clk);
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    logic [3:0] exp_rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        // Idle after reset: row rotation and quiet outputs.
        mask = '0;
        do_reset();
        chk("rst_row_n", kp.row_n, 4'b1110);
        chk("rst_code", kp.key_code, 4'h0);
        chk("rst_valid", kp.key_valid, 1'b0);
        chk("rst_held", kp.key_held, 1'b0);
        for (int k = 1; k < 4; k++) begin
            wait_cycles(4);
            chk("idle_row_seq", kp.row_n, exp_rows[k]);
        end
        wait_scans(2);
        chk("idle_pulses", pulse_cnt, 0);
        chk("idle_held", kp.key_held, 1'b0);

        // Clean press of row 2 / col 1 from the first scan: pulse in the
        // 33rd clock (index 32 from the scan-start edge), code 9.
        mask = 16'h0001 << 9;
        do_reset();
        wait_scans(3);
        chk("press_first_idx", first_idx, 32);
        chk("press_pulses", pulse_cnt, 1);
        chk("press_code", kp.key_code, 4'h9);
        chk("press_held", kp.key_held, 1'b1);
        mask = '0;
        wait_scans(1);
        chk("rel_one_scan_held", kp.key_held, 1'b1);
        wait_scans(1);
        chk("rel_two_scans_held", kp.key_held, 1'b0);
        chk("rel_code_kept", kp.key_code, 4'h9);
        chk("rel_no_pulse", pulse_cnt, 1);

        // Bounce: present, absent, present, present -> one pulse after the 4th scan.
        mask = 16'h0001 << 9;
        do_reset();
        wait_scans(1);
        mask = '0;
        wait_scans(1);
        mask = 16'h0001 << 9;
        wait_scans(2);
        chk("bounce_first_idx", first_idx, 64);
        wait_scans(1);
        chk("bounce_pulses", pulse_cnt, 1);

        // Chord on rows 0 and 3, column 0: ignored; leaving row 3 alone accepts code C.
        mask = 16'h1001;
        do_reset();
        wait_scans(3);
        chk("chord_pulses", pulse_cnt, 0);
        chk("chord_held", kp.key_held, 1'b0);
        mask = 16'h1000;
        wait_scans(2);
        chk("chord_single_pulses", pulse_cnt, 1);
        chk("chord_single_code", kp.key_code, 4'hC);

        // Reset while debouncing a press.
        mask = 16'h0001 << 9;
        do_reset();
        wait_scans(1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_pdb_valid", kp.key_valid, 1'b0);
        chk("rst_pdb_row_n", kp.row_n, 4'b1110);
        #2 reset = 1'b0;
        mask = '0;
        wait_scans(3);
        chk("rst_pdb_pulses", pulse_cnt, 0);

        // Reset while a key is held.
        mask = 16'h0001 << 9;
        do_reset();
        wait_scans(3);
        chk("held_before_rst", kp.key_held, 1'b1);
        pulse_cnt = 0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_held_held", kp.key_held, 1'b0);
        chk("rst_held_code", kp.key_code, 4'h0);
        #2 reset = 1'b0;
        mask = '0;
        wait_scans(3);
        chk("rst_held_pulses", pulse_cnt, 0);

        // Long hold: auto-repeat pulses only when the repeat feature is built in.
        mask = 16'h0001 << 6;
        do_reset();
        wait_scans(10);
        mask = '0;
        wait_scans(3);
        chk("hold10_pulses", pulse_cnt, EXP_HOLD_PULSES);

        // Randomized activity, checked every cycle by the model.
        mask = '0;
        do_reset();
        for (int it = 0; it < 200; it++) begin
            int sel;
            int hold;
            sel = int'($urandom_range(0, 9));
            if (sel < 2) mask = '0;
            else if (sel < 8) mask = 16'h0001 << $urandom_range(0, 15);
            else if (sel == 8) mask = (16'h0001 << $urandom_range(0, 15)) |
                                      (16'h0001 << $urandom_range(0, 15));
            else mask = 16'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                               : int'($urandom_range(16, 96));
            wait_cycles(hold);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                wait_cycles(1);
                reset = 1'b0;
            end
        end
        mask = '0;
        wait_scans(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display path.
- Scans a 4x4 matrix keypad one row at a time, samples the active-low columns, and debounces over whole scans.
- Emits a 4-bit key code with a one-cycle valid pulse, which feeds the value register that drives the display parser.
- Runs on the 2.08 MHz oscillator clock.

Parameters:
- SCAN_DIV, 2080: clock cycles each row is driven (1 ms at 2.08 MHz); must be ≥2.
- DEBOUNCE_SCANS, 5: consecutive identical full scans needed to accept a press or a release; must be ≥1.
- REPEAT_DELAY_SCANS, 125: scans from acceptance to the first auto-repeat (used only with KEYPAD_REPEAT_EN).
- REPEAT_RATE_SCANS, 25: scans between later auto-repeats (used only with KEYPAD_REPEAT_EN).

Ports:
- clk_i, input, 1: system clock, rising-edge.
- reset, input, 1: synchronous, active-high reset.
- col_n_i, input, 4: keypad columns, active low, board pull-ups; treated as already synchronized (2-FF sync is done in the top level).
- row_n_o, output, 4: row drive, active low, exactly one bit low at all times.
- key_code_o, output, 4: code of the accepted key = {row[1:0], col[1:0]}; holds its value until the next acceptance.
- key_valid_o, output, 1: one-cycle pulse when a key is accepted (or auto-repeats).
- key_held_o, output, 1: high while an accepted key is considered down.

Behaviour:
- Reset (reset=1 at a clock edge) has priority over everything:
  - row_n_o=4'b1110, key_code_o=0, key_valid_o=0, key_held_o=0.
  - Row index 0, dwell counter 0, snapshot cleared, state IDLE, all scan counters 0.
  - A reset mid-press discards the press; no pulse is produced.
- Row scan:
  - Dwell counter runs 0..SCAN_DIV-1 for each row. row_n_o = ~(4'b0001 << r).
  - Columns are sampled only on dwell cycle SCAN_DIV-1 (settle time). Column c pressed means col_n_i[c]=0.
  - After that sample the row index advances; 3 wraps to 0.
  - One full scan = 4*SCAN_DIV cycles.
- Scan evaluation happens on the row-3 sample cycle, using a 16-bit snapshot in which bit {r,c} is set if pressed:
  - Exactly one bit set: candidate = that code, cand_valid = 1.
  - Zero bits set, or two or more (ghosting/chord): cand_valid = 0.
- FSM state updates only at scan-evaluation edges:
  - IDLE:
    - cand_valid: latch pending code, count=1, go to PRESS_DB.
    - If DEBOUNCE_SCANS=1, accept immediately instead (same as the PRESS_DB accept path).
  - PRESS_DB:
    - Candidate valid and equal to pending: count++. When count reaches DEBOUNCE_SCANS, accept and go to HELD.
    - Candidate invalid: go to IDLE, count=0.
    - Candidate valid but different: restart with the new code, count=1.
  - Accept: key_code_o <= pending, key_held_o <= 1. key_valid_o is high for exactly the one clock after the evaluation edge.
  - HELD:
    - Candidate not equal to held code (including none or a different key): count=1, go to REL_DB.
    - Otherwise stay.
  - REL_DB:
    - Candidate equal to held code: back to HELD, count=0.
    - Otherwise count++. When count reaches DEBOUNCE_SCANS: key_held_o <= 0, go to IDLE. No pulse on release.
  - A different key pressed while another is held is reported only after a full release, then re-detected from IDLE.
- Latency: a clean press present across the entire scans has key_valid_o asserted DEBOUNCE_SCANS scans after the first scan that sees it, plus 1 clock.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD (not REL_DB), a repeat counter counts scans from acceptance.
  - At REPEAT_DELAY_SCANS, and every REPEAT_RATE_SCANS after that, key_valid_o pulses one cycle with key_code_o unchanged.
  - Entering REL_DB freezes the counter. Returning to HELD resumes it. Going to IDLE clears it.
- Not defined: exactly one key_valid_o pulse per accepted press. Repeat parameters are unused and no repeat counter is synthesized.

Test Plan:
- Bench parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_DELAY_SCANS=4, REPEAT_RATE_SCANS=2.
- Reset then idle, no keys:
  - row_n_o cycles 1110, 1101, 1011, 0111 every 4 clocks.
  - key_valid_o=0, key_held_o=0, key_code_o=0.
- Press row 2 / col 1 (col_n_i=4'b1101 while row_n_o=4'b1011), starting before a scan:
  - key_code_o=4'h9 and key_valid_o high for 1 cycle, 2 scans + 1 clock (33 clocks) after that scan starts.
  - key_held_o=1 until 2 key-free scans complete.
- Bounce: key present in scan 1, absent in scan 2, present in scans 3-4 -> one pulse only, after scan 4.
- Two keys in the same scan (rows 0 and 3, col 0) -> no pulse. Releasing one leaves a single key -> accepted after 2 scans with the correct code.
- Reset asserted during PRESS_DB, and separately during HELD -> outputs return to reset values on the next edge; no pulse appears.
- KEYPAD_REPEAT_EN defined, key held 10 scans -> pulses at acceptance, +4 scans, +6, +8. Without the macro -> a single pulse only.
